// File: rtl/usart_tx_arbiter_if.sv
// usart_tx_arbiter_if: request/frame/ack/done handshakes for two frame
// requesters, plus the byte strobe bus towards uart_send.
// master = requester/consumer side, slave = the arbiter.
interface usart_tx_arbiter_if #(
  parameter int FRAME_BYTES = 5
);
  logic                     req0;
  logic [8*FRAME_BYTES-1:0] frame0;
  logic                     ack0;
  logic                     done0;
  logic                     req1;
  logic [8*FRAME_BYTES-1:0] frame1;
  logic                     ack1;
  logic                     done1;
  logic                     tx_byte_en;
  logic [7:0]               tx_byte;
  logic                     busy;

  modport master (
    output req0, frame0, req1, frame1,
    input  ack0, done0, ack1, done1, tx_byte_en, tx_byte, busy
  );

  modport slave (
    input  req0, frame0, req1, frame1,
    output ack0, done0, ack1, done1, tx_byte_en, tx_byte, busy
  );
endinterface

// File: rtl/usart_tx_arbiter.sv
// usart_tx_arbiter: round-robin scheduler sharing one uart_send byte
// transmitter between two fixed-length frame requesters. Bytes go out
// MSB-first, each paced by a 10*BPS_CNT-cycle slot timer.
// Optional feature: define USART_TX_ARB_CHKSUM_EN to append an XOR checksum
// byte after the frame bytes.
module usart_tx_arbiter #(
  parameter logic [15:0] BPS_CNT     = 16'd434,
  parameter int          FRAME_BYTES = 5
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  usart_tx_arbiter_if.slave bus
);

  localparam int FW = 8 * FRAME_BYTES;
`ifdef USART_TX_ARB_CHKSUM_EN
  localparam int NBYTES = FRAME_BYTES + 1;
`else
  localparam int NBYTES = FRAME_BYTES;
`endif
  localparam int              IW        = $clog2(FRAME_BYTES + 1);
  localparam int unsigned     SLOT      = 10 * BPS_CNT;
  localparam logic [15:0]     SLOT_LAST = 16'(SLOT - 1);
  localparam logic [IW-1:0]   LAST_IDX  = IW'(NBYTES - 1);
`ifdef USART_TX_ARB_CHKSUM_EN
  localparam logic [IW-1:0]   LAST_FRAME_IDX = IW'(FRAME_BYTES - 1);
`endif

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] shift_q, shift_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          last_grant_q, last_grant_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_byte_en_q, tx_byte_en_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;
  logic          busy_q, busy_d;
`ifdef USART_TX_ARB_CHKSUM_EN
  logic [7:0]    chk_q, chk_d;
`endif

  logic          grant0;
  logic          grant1;
  logic [FW-1:0] shifted;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign grant1  = bus.req1 && (!bus.req0 || !last_grant_q);
  assign grant0  = bus.req0 && !grant1;
  assign shifted = shift_q << 8;

  // Next-state and next-output computation for the IDLE/SEND/DONE sequencer.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    last_grant_d = last_grant_q;
    tx_byte_d    = tx_byte_q;
    tx_byte_en_d = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
`ifdef USART_TX_ARB_CHKSUM_EN
    chk_d        = chk_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          state_d      = SEND;
          shift_d      = grant1 ? bus.frame1 : bus.frame0;
          last_grant_d = grant1;
          ack0_d       = grant0;
          ack1_d       = grant1;
          tx_byte_d    = shift_d[FW-1 -: 8];
          tx_byte_en_d = 1'b1;
          cnt_d        = 16'd0;
          idx_d        = '0;
`ifdef USART_TX_ARB_CHKSUM_EN
          chk_d        = shift_d[FW-1 -: 8];
`endif
        end
      end
      SEND: begin
        if (cnt_q == SLOT_LAST) begin
          if (idx_q == LAST_IDX) begin
            // Final slot over: report completion to whoever holds the grant.
            state_d   = DONE;
            done0_d   = !last_grant_q;
            done1_d   = last_grant_q;
            tx_byte_d = 8'h00;
          end else begin
            cnt_d        = 16'd0;
            idx_d        = idx_q + 1'b1;
            tx_byte_en_d = 1'b1;
`ifdef USART_TX_ARB_CHKSUM_EN
            if (idx_q == LAST_FRAME_IDX) begin
              tx_byte_d = chk_q;
            end else begin
              shift_d   = shifted;
              tx_byte_d = shifted[FW-1 -: 8];
              chk_d     = chk_q ^ shifted[FW-1 -: 8];
            end
`else
            shift_d   = shifted;
            tx_byte_d = shifted[FW-1 -: 8];
`endif
          end
        end else begin
          cnt_d        = cnt_q + 16'd1;
          // Strobe spans counts 0 and 1 of each slot.
          tx_byte_en_d = (cnt_q == 16'd0);
        end
      end
      DONE: begin
        state_d   = IDLE;
        tx_byte_d = 8'h00;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any frame without a done pulse.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      cnt_q        <= 16'd0;
      idx_q        <= '0;
      last_grant_q <= 1'b1;
      tx_byte_q    <= 8'h00;
      tx_byte_en_q <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      busy_q       <= 1'b0;
`ifdef USART_TX_ARB_CHKSUM_EN
      chk_q        <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      last_grant_q <= last_grant_d;
      tx_byte_q    <= tx_byte_d;
      tx_byte_en_q <= tx_byte_en_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      busy_q       <= busy_d;
`ifdef USART_TX_ARB_CHKSUM_EN
      chk_q        <= chk_d;
`endif
    end
  end

  assign bus.tx_byte    = tx_byte_q;
  assign bus.tx_byte_en = tx_byte_en_q;
  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.done0      = done0_q;
  assign bus.done1      = done1_q;
  assign bus.busy       = busy_q;

endmodule
